mlp_layer_ctrl: RTL and testbench

MLP_LAYER_CTRL -- requirements
Module: mlp_layer_ctrl

---
 rtl/mlp_layer_ctrl_if.sv | 71 +++++++
 rtl/mlp_layer_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mlp_layer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_ctrl_if.sv
// -----------------------------------------------------------------------------
// mlp_layer_ctrl_if
//
// Purpose: bundles the control/handshake signals between the MLP layer
// sequencer (mlp_layer_ctrl) and the datapath or an observer.
//
// Parameters:
//   N_IN  : inputs per neuron (2..1024)
//   N_NEU : neurons per layer (1..256)
//
// Signals:
//   start    : single-cycle request to run one layer (sampled only in IDLE)
//   busy     : high whenever the sequencer is not IDLE
//   done     : one-cycle pulse at layer completion
//   in_idx   : input/weight memory address for the current MAC step
//   neu_idx  : index of the neuron being computed
//   acc_clr  : synchronous clear for the accumulator register
//   acc_en   : load enable for the accumulator register
//   out_en   : load enable for the neuron result register of neu_idx
//   bias_sel : adder takes the bias instead of weight*input (0 when the bias
//              feature is not compiled in)
//
// Modports:
//   master : the sequencer (drives everything except start)
//   slave  : the requester / datapath side (drives start)
//
// Handshake: start is a level sampled on the rising clock edge only while
// the sequencer is IDLE; there is no ready signal -- busy low means the next
// start will be accepted, and done marks the final cycle of a layer run.
// -----------------------------------------------------------------------------
interface mlp_layer_ctrl_if #(
  parameter int N_IN  = 62,
  parameter int N_NEU = 10
);
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int NW = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] in_idx;
  logic [NW-1:0] neu_idx;
  logic          acc_clr;
  logic          acc_en;
  logic          out_en;
  logic          bias_sel;

  modport master (
    input  start,
    output busy,
    output done,
    output in_idx,
    output neu_idx,
    output acc_clr,
    output acc_en,
    output out_en,
    output bias_sel
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  in_idx,
    input  neu_idx,
    input  acc_clr,
    input  acc_en,
    input  out_en,
    input  bias_sel
  );
endinterface

// File: rtl/mlp_layer_ctrl.sv
// -----------------------------------------------------------------------------
// mlp_layer_ctrl
//
// Purpose: sequencer for one fully-connected MLP layer. For every neuron it
// clears the accumulator, runs N_IN multiply-accumulate steps while walking
// the input/weight address, optionally adds the bias, and writes the result
// register of that neuron. After the last neuron it pulses done and returns
// to IDLE.
//
// Per-neuron sequence:
//   default build            : CLR, N_IN x MAC, WB
//   MLP_LAYER_CTRL_BIAS_EN   : CLR, N_IN x MAC, BIAS, WB
// followed once per layer by DONE.
//
// Optional feature macro: MLP_LAYER_CTRL_BIAS_EN (enables the BIAS state and
// drives bias_sel; without it bias_sel is tied 0 and BIAS is unreachable).
//
// Parameters:
//   N_IN  : inputs per neuron (2..1024), IW = clog2(N_IN)
//   N_NEU : neurons per layer (1..256),  NW = clog2(N_NEU), minimum 1
//
// Ports:
//   clk         : clock, all state changes on its rising edge
//   rst         : asynchronous active-low reset, forces IDLE immediately
//   bus         : mlp_layer_ctrl_if.master (start in; busy, done, in_idx,
//                 neu_idx, acc_clr, acc_en, out_en, bias_sel out)
//   dbg_state_o : current FSM state encoding, for checkers and debug
//
// All strobes (acc_clr, acc_en, out_en, bias_sel, done) are decoded from the
// registered state only, so they are glitch-free Moore outputs and drop to 0
// as soon as rst is asserted.
// -----------------------------------------------------------------------------
module mlp_layer_ctrl #(
  parameter int N_IN  = 62,
  parameter int N_NEU = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mlp_layer_ctrl_if.master     bus,
  output logic [2:0]           dbg_state_o
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int NW = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [NW-1:0] NEU_LAST = NW'(N_NEU - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_BIAS = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [NW-1:0] neu_idx_q, neu_idx_d;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      in_idx_q  <= '0;
      neu_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      neu_idx_q <= neu_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    neu_idx_d = neu_idx_q;

    unique case (state_q)
      S_IDLE: begin
        // start is only looked at here, so a start held through DONE or
        // asserted mid-layer never queues a second run.
        if (bus.start) begin
          state_d   = S_CLR;
          in_idx_d  = '0;
          neu_idx_d = '0;
        end
      end

      S_CLR: begin
        state_d = S_MAC;
      end

      S_MAC: begin
        if (in_idx_q == IN_LAST) begin
          // Wrap here so the next neuron's first MAC already sees address 0.
          in_idx_d = '0;
`ifdef MLP_LAYER_CTRL_BIAS_EN
          state_d  = S_BIAS;
`else
          state_d  = S_WB;
`endif
        end else begin
          in_idx_d = in_idx_q + IW'(1);
        end
      end

      S_BIAS: begin
        state_d = S_WB;
      end

      S_WB: begin
        if (neu_idx_q == NEU_LAST) begin
          state_d = S_DONE;
        end else begin
          neu_idx_d = neu_idx_q + NW'(1);
          state_d   = S_CLR;
        end
      end

      S_DONE: begin
        // neu_idx still names the last neuron during DONE and is cleared on
        // the way back to IDLE.
        neu_idx_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        in_idx_d  = '0;
        neu_idx_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  logic busy_w, done_w, acc_clr_w, acc_en_w, out_en_w, bias_sel_w;

  always_comb begin
    busy_w     = 1'b0;
    done_w     = 1'b0;
    acc_clr_w  = 1'b0;
    acc_en_w   = 1'b0;
    out_en_w   = 1'b0;
    bias_sel_w = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_w = 1'b0;
      end
      S_CLR: begin
        busy_w    = 1'b1;
        acc_clr_w = 1'b1;
      end
      S_MAC: begin
        busy_w   = 1'b1;
        acc_en_w = 1'b1;
      end
      S_BIAS: begin
        busy_w = 1'b1;
`ifdef MLP_LAYER_CTRL_BIAS_EN
        // The bias is added through the same accumulator load path.
        acc_en_w   = 1'b1;
        bias_sel_w = 1'b1;
`endif
      end
      S_WB: begin
        busy_w   = 1'b1;
        out_en_w = 1'b1;
      end
      S_DONE: begin
        busy_w = 1'b1;
        done_w = 1'b1;
      end
      default: begin
        busy_w = 1'b0;
      end
    endcase
  end

  assign bus.busy     = busy_w;
  assign bus.done     = done_w;
  assign bus.acc_clr  = acc_clr_w;
  assign bus.acc_en   = acc_en_w;
  assign bus.out_en   = out_en_w;
  assign bus.bias_sel = bias_sel_w;
  assign bus.in_idx   = in_idx_q;
  assign bus.neu_idx  = neu_idx_q;

  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mlp_layer_ctrl
//
// Three controllers with different shapes (62x10, 4x3, 2x1) share clock,
// reset and start. A reference model expands each accepted start into the
// full list of expected per-cycle outputs of the layer (one entry per
// cycle); one compare process pops that list each cycle and checks every
// output of every instance. Directed phases pin latency and strobe counts
// with hand-computed literals, then random start/reset traffic follows.
// -----------------------------------------------------------------------------
module tb_mlp_layer_ctrl;

  localparam int NINST = 3;
  localparam int NI [NINST] = '{62, 4, 2};
  localparam int NN [NINST] = '{10, 3, 1};

`ifdef MLP_LAYER_CTRL_BIAS_EN
  localparam bit USE_BIAS = 1'b1;
  // done cycle counted with the start cycle as cycle 0: N_NEU*(N_IN+3)+1
  localparam int EXP_DONE [NINST] = '{651, 22, 6};
  localparam int EXP_ACC  [NINST] = '{630, 15, 3};
  localparam int EXP_BIAS [NINST] = '{10, 3, 1};
`else
  localparam bit USE_BIAS = 1'b0;
  // done cycle counted with the start cycle as cycle 0: N_NEU*(N_IN+2)+1
  localparam int EXP_DONE [NINST] = '{641, 19, 5};
  localparam int EXP_ACC  [NINST] = '{620, 12, 2};
  localparam int EXP_BIAS [NINST] = '{0, 0, 0};
`endif
  localparam int EXP_OUT [NINST] = '{10, 3, 1};

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        acc_clr;
    logic        acc_en;
    logic        out_en;
    logic        bias_sel;
    logic [15:0] in_idx;
    logic [15:0] neu_idx;
  } obs_t;

  localparam int OW = $bits(obs_t);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  obs_t       act [NINST];
  logic [2:0] dbg [NINST];

  generate
    for (genvar g = 0; g < NINST; g++) begin : g_dut
      mlp_layer_ctrl_if #(.N_IN(NI[g]), .N_NEU(NN[g])) bus ();
      assign bus.start = start;
      mlp_layer_ctrl #(.N_IN(NI[g]), .N_NEU(NN[g])) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .dbg_state_o (dbg[g])
      );
      assign act[g] = {bus.busy, bus.done, bus.acc_clr, bus.acc_en, bus.out_en,
                       bus.bias_sel, 16'(bus.in_idx), 16'(bus.neu_idx)};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] exp_q [NINST][$];
  obs_t cur      [NINST];
  bit   idle_m   [NINST];
  bit   run_on   [NINST];
  int   run_cyc  [NINST];
  int   acc_cnt  [NINST];
  int   out_cnt  [NINST];
  int   bias_cnt [NINST];
  int   done_cyc [NINST];
  int   done_tot [NINST];

  function automatic obs_t mk(bit busy, bit dn, bit clr, bit en, bit oe, bit bs,
                              int ii, int nn);
    obs_t o;
    o.busy     = busy;
    o.done     = dn;
    o.acc_clr  = clr;
    o.acc_en   = en;
    o.out_en   = oe;
    o.bias_sel = bs;
    o.in_idx   = 16'(ii);
    o.neu_idx  = 16'(nn);
    return o;
  endfunction

  // One accepted start expands into the whole layer's cycle-by-cycle outputs.
  function automatic void build_layer(int g);
    for (int n = 0; n < NN[g]; n++) begin
      exp_q[g].push_back(mk(1, 0, 1, 0, 0, 0, 0, n));
      for (int i = 0; i < NI[g]; i++)
        exp_q[g].push_back(mk(1, 0, 0, 1, 0, 0, i, n));
      if (USE_BIAS)
        exp_q[g].push_back(mk(1, 0, 0, 1, 0, 1, 0, n));
      exp_q[g].push_back(mk(1, 0, 0, 0, 1, 0, 0, n));
    end
    exp_q[g].push_back(mk(1, 1, 0, 0, 0, 0, 0, NN[g] - 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Model advance + compare, every cycle and on every reset assertion
  // ---------------------------------------------------------------------------
  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < NINST; g++) begin
      if (!rst) begin
        exp_q[g].delete();
        cur[g]    = '0;
        idle_m[g] = 1'b1;
        run_on[g] = 1'b0;
      end else begin
        if (idle_m[g] && start === 1'b1) begin
          build_layer(g);
          run_on[g]   = 1'b1;
          run_cyc[g]  = 0;
          acc_cnt[g]  = 0;
          out_cnt[g]  = 0;
          bias_cnt[g] = 0;
          done_cyc[g] = -1;
        end
        if (exp_q[g].size() > 0) begin
          cur[g]    = obs_t'(exp_q[g].pop_front());
          idle_m[g] = 1'b0;
          if (run_on[g]) run_cyc[g]++;
        end else begin
          cur[g]    = '0;
          idle_m[g] = 1'b1;
          run_on[g] = 1'b0;
        end
      end
    end
    #1;
    for (int g = 0; g < NINST; g++) begin
      checks++;
      if (act[g] !== cur[g]) begin
        failures++;
        $display("FAIL cycle_outputs inst%0d t=%0t got busy=%b done=%b clr=%b en=%b oe=%b bs=%b in=%0d neu=%0d exp busy=%b done=%b clr=%b en=%b oe=%b bs=%b in=%0d neu=%0d",
                 g, $time, act[g].busy, act[g].done, act[g].acc_clr, act[g].acc_en,
                 act[g].out_en, act[g].bias_sel, act[g].in_idx, act[g].neu_idx,
                 cur[g].busy, cur[g].done, cur[g].acc_clr, cur[g].acc_en,
                 cur[g].out_en, cur[g].bias_sel, cur[g].in_idx, cur[g].neu_idx);
      end
      if (act[g].done === 1'b1) done_tot[g]++;
      if (run_on[g]) begin
        if (act[g].acc_en === 1'b1)   acc_cnt[g]++;
        if (act[g].out_en === 1'b1)   out_cnt[g]++;
        if (act[g].bias_sel === 1'b1) bias_cnt[g]++;
        if (act[g].done === 1'b1 && done_cyc[g] < 0) done_cyc[g] = run_cyc[g];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit idle_all;
    idle_all = 1'b0;
    for (int k = 0; k < budget && !idle_all; k++) begin
      @(negedge clk);
      idle_all = 1'b1;
      for (int g = 0; g < NINST; g++)
        if (act[g].busy !== 1'b0) idle_all = 1'b0;
    end
    checks++;
    if (!idle_all) begin
      failures++;
      $display("FAIL %s_timeout got=busy exp=idle within %0d cycles", tag, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    int base;

    for (int g = 0; g < NINST; g++) begin
      done_tot[g] = 0;
      done_cyc[g] = -1;
      acc_cnt[g]  = 0;
      out_cnt[g]  = 0;
      bias_cnt[g] = 0;
      run_cyc[g]  = 0;
    end
    rst   = 1'b1;
    start = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NINST; g++)
      chk($sformatf("reset_outputs_inst%0d", g), longint'(act[g]), 0);
    rst = 1'b1;

    // Single clean layer on every instance: latency and strobe counts.
    pulse_start();
    chk("busy_after_start_inst1", longint'(act[1].busy), 1);
    wait_idle(900, "single_run");
    for (int g = 0; g < NINST; g++) begin
      chk($sformatf("done_cycle_inst%0d", g), done_cyc[g], EXP_DONE[g]);
      chk($sformatf("acc_en_count_inst%0d", g), acc_cnt[g], EXP_ACC[g]);
      chk($sformatf("out_en_count_inst%0d", g), out_cnt[g], EXP_OUT[g]);
      chk($sformatf("bias_sel_count_inst%0d", g), bias_cnt[g], EXP_BIAS[g]);
    end

    // start held high for 30 cycles: the 4x3 instance completes one layer
    // and has started a second one only after passing through IDLE.
    @(negedge clk);
    start = 1'b1;
    base  = done_tot[1];
    repeat (30) @(negedge clk);
    chk("held_start_done_count_inst1", done_tot[1] - base, 1);
    chk("held_start_rerun_busy_inst1", longint'(act[1].busy), 1);
    start = 1'b0;
    wait_idle(1500, "held_start");

    // Reset during neuron 1, in_idx 2 of the 4x3 instance.
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (act[1].neu_idx == 16'd1 && act[1].in_idx == 16'd2 && act[1].acc_en === 1'b1)
        found = 1'b1;
      else
        @(negedge clk);
    end
    chk("reach_neuron1_in2", longint'(found), 1);
    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < NINST; g++)
      chk($sformatf("async_reset_outputs_inst%0d", g), longint'(act[g]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume_after_reset_inst1", longint'(act[1].busy), 0);
    pulse_start();
    chk("restart_acc_clr_inst1", longint'(act[1].acc_clr), 1);
    chk("restart_neu_idx_inst1", longint'(act[1].neu_idx), 0);
    chk("restart_in_idx_inst1", longint'(act[1].in_idx), 0);
    wait_idle(900, "after_reset");

    // Random start traffic with occasional asynchronous resets.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    start = 1'b0;
    wait_idle(900, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
